excess3_bcd_seq_ctrl: RTL

EXCESS3_BCD_SEQ_CTRL -- requirements
Module: excess3_bcd_seq_ctrl

---
 rtl/excess3_bcd_seq_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/excess3_bcd_seq_ctrl.sv
// excess3_bcd_seq_ctrl
// Sequential excess-3 to BCD word converter. A captured word is converted one
// digit per clock through a single shared 4-bit converter, least significant
// digit first, and the result is held until the consumer takes it.
//
// Handshake (both ports): a transfer happens on a rising clk edge where the
// producer's valid and the consumer's ready are both 1. in_ready is 1 only in
// IDLE (and never while rst_n is low). out_valid is 1 only in DONE, and
// out_data/out_err stay frozen until the edge that transfers the word.
//
// Compile-time option: EXCESS3_ERR_DETECT_EN
//   defined   -> invalid digits (outside 4'h3..4'hC) convert to 4'hF and set out_err
//   undefined -> every digit is plain subtract-3 mod 16, out_err is tied to 0
module excess3_bcd_seq_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_err,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  sreg;
  logic [2:0]    cnt;
  logic [3:0]    cur_digit;
  logic [3:0]    conv_digit;
  logic          last_digit;

  // The digit being converted always sits in the low nibble of the shift register.
  assign cur_digit  = sreg[3:0];
  assign last_digit = (cnt == 3'(DIGITS - 1));

  assign in_ready  = rst_n && (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

`ifdef EXCESS3_ERR_DETECT_EN
  logic conv_bad;
  logic err_q;

  // Shared digit converter: out-of-range digits map to 4'hF and are flagged.
  always_comb begin
    conv_bad   = (cur_digit < 4'h3) || (cur_digit > 4'hC);
    conv_digit = conv_bad ? 4'hF : (cur_digit - 4'h3);
  end

  assign out_err = err_q;
`else
  // Shared digit converter: plain subtract-3, wrapping mod 16.
  always_comb begin
    conv_digit = cur_digit - 4'h3;
  end

  assign out_err = 1'b0;
`endif

  // Control FSM with its datapath registers; all outputs except the state
  // decodes are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      sreg      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef EXCESS3_ERR_DETECT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg     <= in_data;
            cnt      <= 3'd0;
            out_data <= '0;
`ifdef EXCESS3_ERR_DETECT_EN
            err_q    <= 1'b0;
`endif
            state    <= CONV;
          end
        end
        CONV: begin
          // Each converted digit enters at the top and drifts down, so after
          // DIGITS steps digit 0 lands in the least significant nibble.
          out_data <= W'({conv_digit, out_data} >> 4);
          sreg     <= sreg >> 4;
`ifdef EXCESS3_ERR_DETECT_EN
          err_q    <= err_q | conv_bad;
`endif
          if (last_digit) begin
            cnt       <= 3'd0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
